apb_gpio_uart_subsystem: RTL and testbench

- APB subsystem: one APB master bridge driven by a simple command interface, fanned out to two APB slaves.
  - Slave 0: 8-pin bidirectional GPIO.
  - Slave 1: UART (8 data bits, even parity, 1 stop bit).
- Top-level peripheral block. Gives a processor-side command port access to pins and a serial line.

---
 rtl/apb_gpio_uart_subsystem.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_apb_gpio_uart_subsystem.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_gpio_uart_subsystem.sv
`default_nettype none
// ============================================================================
// Module   : apb_gpio_uart_subsystem
// Brief    : APB master bridge fanned out to an 8-pin GPIO and an 8E1 UART.
//            Define APB_SLVERR_EN to enable PSLVERR error reporting.
// Revision : 1.0 - initial release
// ============================================================================
module apb_gpio_uart_subsystem #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STROBE_WIDTH = 4,
    parameter int SLAVES_NUM   = 2,
    parameter int CLOCK_RATE   = 100000000,
    parameter int BAUD_RATE    = 9600
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [ADDR_WIDTH-1:0]   top_ADDR_in,
    input  logic [DATA_WIDTH-1:0]   top_DATA_in,
    input  logic [2:0]              top_PROT_in,
    input  logic [SLAVES_NUM-1:0]   top_SEL_in,
    input  logic [STROBE_WIDTH-1:0] top_STROB_in,
    input  logic                    top_Transfer,
    input  logic                    top_WRITE_in,
    input  logic                    top_UART_rx,
    output logic                    top_SLVERR_out,
    output logic [DATA_WIDTH-1:0]   top_DATA_out,
    output logic                    top_UART_tx,
    inout  wire  [7:0]              GPIO_PINS
);
    localparam int DIV  = CLOCK_RATE / BAUD_RATE;
    localparam int HALF = DIV / 2;
    localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] c_div_last  = CW'(DIV - 1);
    localparam logic [CW-1:0] c_half_last = CW'(HALF - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_START = 2'd1,
        R_DATA  = 2'd2
    } rx_state_t;

    state_t                  state_q;
    logic                    penable_q;
    logic [DATA_WIDTH-1:0]   data_out_q;
    logic                    slverr_q;
    logic [ADDR_WIDTH-1:0]   paddr_q;
    logic [DATA_WIDTH-1:0]   pwdata_q;
    logic                    pwrite_q;
    logic [SLAVES_NUM-1:0]   psel_q;
    logic [2:0]              pprot_q;
    logic [STROBE_WIDTH-1:0] pstrb_q;

    logic                  w_sel_gpio, w_sel_uart, w_sel_valid;
    logic                  w_gpio_acc, w_uart_acc;
    logic                  w_pready, w_pslverr, w_load;
    logic [1:0]            w_addr;
    logic [7:0]            w_gpio_rdata, w_uart_rdata;
    logic [DATA_WIDTH-1:0] w_prdata;

    assign w_addr      = paddr_q[1:0];
    assign w_sel_gpio  = (psel_q == SLAVES_NUM'(1));
    assign w_sel_uart  = (psel_q == SLAVES_NUM'(2));
    assign w_sel_valid = w_sel_gpio || w_sel_uart;
    assign w_gpio_acc  = penable_q && w_sel_gpio;
    assign w_uart_acc  = penable_q && w_sel_uart;
    // Without a valid slave the master terminates the access itself.
    assign w_pready    = w_sel_valid ? (w_gpio_acc || w_uart_acc) : 1'b1;
    assign w_load      = top_Transfer &&
                         ((state_q == S_IDLE) || ((state_q == S_ACCESS) && w_pready));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            penable_q  <= 1'b0;
            data_out_q <= '0;
            slverr_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (top_Transfer) state_q <= S_SETUP;
                end
                S_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (w_pready) begin
                        penable_q <= 1'b0;
                        slverr_q  <= w_pslverr;
                        if (!pwrite_q) data_out_q <= w_prdata;
                        state_q   <= top_Transfer ? S_SETUP : S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            psel_q   <= '0;
            pprot_q  <= '0;
            pstrb_q  <= '0;
        end else if (w_load) begin
            paddr_q  <= top_ADDR_in;
            pwdata_q <= top_DATA_in;
            pwrite_q <= top_WRITE_in;
            psel_q   <= top_SEL_in;
            pprot_q  <= top_PROT_in;
            pstrb_q  <= top_STROB_in;
        end
    end

    assign w_prdata = w_sel_gpio ? DATA_WIDTH'(w_gpio_rdata) :
                      w_sel_uart ? DATA_WIDTH'(w_uart_rdata) : '0;

    assign top_DATA_out   = data_out_q;
    assign top_SLVERR_out = slverr_q;

    // ---------------- GPIO slave ----------------
    logic [7:0] dir_q, port_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            dir_q  <= 8'd0;
            port_q <= 8'd0;
        end else if (w_gpio_acc && pwrite_q) begin
            if (w_addr == 2'd2) dir_q  <= pwdata_q[7:0];
            if (w_addr == 2'd3) port_q <= pwdata_q[7:0];
        end
    end

    for (genvar i = 0; i < 8; i++) begin : g_pin
        assign GPIO_PINS[i] = dir_q[i] ? port_q[i] : 1'bz;
    end

    always_comb begin
        w_gpio_rdata = 8'd0;
        case (w_addr)
            2'd0:    w_gpio_rdata = GPIO_PINS;
            2'd2:    w_gpio_rdata = dir_q;
            2'd3:    w_gpio_rdata = port_q;
            default: w_gpio_rdata = 8'd0;
        endcase
    end

    // ---------------- UART transmitter ----------------
    logic          tx_busy_q, tx_q;
    logic [9:0]    tx_shift_q;
    logic [3:0]    tx_bit_q;
    logic [CW-1:0] tx_cnt_q;
    logic          w_tx_start;

    assign w_tx_start  = w_uart_acc && pwrite_q && (w_addr == 2'd0) && !tx_busy_q;
    assign top_UART_tx = tx_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tx_busy_q  <= 1'b0;
            tx_q       <= 1'b1;
            tx_shift_q <= 10'd0;
            tx_bit_q   <= 4'd0;
            tx_cnt_q   <= '0;
        end else if (w_tx_start) begin
            tx_busy_q  <= 1'b1;
            tx_q       <= 1'b0;
            tx_shift_q <= {1'b1, ^pwdata_q[7:0], pwdata_q[7:0]};
            tx_bit_q   <= 4'd0;
            tx_cnt_q   <= '0;
        end else if (tx_busy_q) begin
            if (tx_cnt_q == c_div_last) begin
                tx_cnt_q <= '0;
                // Index 10 means the stop bit has been on the line a full period.
                if (tx_bit_q == 4'd10) begin
                    tx_busy_q <= 1'b0;
                    tx_q      <= 1'b1;
                end else begin
                    tx_q       <= tx_shift_q[0];
                    tx_shift_q <= {1'b0, tx_shift_q[9:1]};
                    tx_bit_q   <= tx_bit_q + 4'd1;
                end
            end else begin
                tx_cnt_q <= tx_cnt_q + CW'(1);
            end
        end
    end

    // ---------------- UART receiver ----------------
    rx_state_t     rx_state_q;
    logic          rx_s1_q, rx_s2_q, rx_prev_q;
    logic [CW-1:0] rx_cnt_q;
    logic [3:0]    rx_bit_q;
    logic [8:0]    rx_shift_q;
    logic [7:0]    rxdata_q;
    logic          rx_valid_q, perr_q, ferr_q;
    logic          w_rx_rd;

    assign w_rx_rd = w_uart_acc && !pwrite_q && (w_addr == 2'd1);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_state_q <= R_IDLE;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_cnt_q   <= '0;
            rx_bit_q   <= 4'd0;
            rx_shift_q <= 9'd0;
            rxdata_q   <= 8'd0;
            rx_valid_q <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            rx_s1_q   <= top_UART_rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            if (w_rx_rd) begin
                rx_valid_q <= 1'b0;
                perr_q     <= 1'b0;
                ferr_q     <= 1'b0;
            end
            case (rx_state_q)
                R_IDLE: begin
                    if (rx_prev_q && !rx_s2_q) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= R_START;
                    end
                end
                R_START: begin
                    if (rx_cnt_q == c_half_last) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= 4'd0;
                        rx_state_q <= rx_s2_q ? R_IDLE : R_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CW'(1);
                    end
                end
                R_DATA: begin
                    if (rx_cnt_q == c_div_last) begin
                        rx_cnt_q <= '0;
                        // Bits 0..8 are data and parity; bit 9 is the stop bit.
                        if (rx_bit_q == 4'd9) begin
                            rxdata_q   <= rx_shift_q[7:0];
                            rx_valid_q <= 1'b1;
                            perr_q     <= perr_q | (^rx_shift_q);
                            ferr_q     <= ferr_q | !rx_s2_q;
                            rx_state_q <= R_IDLE;
                        end else begin
                            rx_shift_q <= {rx_s2_q, rx_shift_q[8:1]};
                            rx_bit_q   <= rx_bit_q + 4'd1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CW'(1);
                    end
                end
                default: rx_state_q <= R_IDLE;
            endcase
        end
    end

    always_comb begin
        w_uart_rdata = 8'd0;
        case (w_addr)
            2'd1:    w_uart_rdata = rxdata_q;
            2'd2:    w_uart_rdata = {4'd0, ferr_q, perr_q, rx_valid_q, tx_busy_q};
            default: w_uart_rdata = 8'd0;
        endcase
    end

    // ---------------- error response ----------------
`ifdef APB_SLVERR_EN
    logic w_gpio_err, w_uart_err;
    assign w_gpio_err = w_gpio_acc && ((w_addr == 2'd1) || (pwrite_q && (w_addr == 2'd0)));
    assign w_uart_err = w_uart_acc && ((w_addr == 2'd3) ||
                        (pwrite_q && ((w_addr == 2'd1) || (w_addr == 2'd2))) ||
                        (pwrite_q && (w_addr == 2'd0) && tx_busy_q));
    assign w_pslverr  = penable_q && (!w_sel_valid || w_gpio_err || w_uart_err);
`else
    assign w_pslverr  = 1'b0;
`endif

    logic w_unused;
    assign w_unused = ^{paddr_q[ADDR_WIDTH-1:2], pwdata_q[DATA_WIDTH-1:8], pprot_q, pstrb_q};

endmodule
`default_nettype wire

// File: tb/tb_apb_gpio_uart_subsystem.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_gpio_uart_subsystem
// Brief    : Scoreboard bench for the APB GPIO/UART subsystem.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_gpio_uart_subsystem;
    localparam int DIV = 16;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] top_ADDR_in;
    logic [31:0] top_DATA_in;
    logic [2:0]  top_PROT_in;
    logic [1:0]  top_SEL_in;
    logic [3:0]  top_STROB_in;
    logic        top_Transfer;
    logic        top_WRITE_in;
    logic        top_UART_rx;
    logic        top_SLVERR_out;
    logic [31:0] top_DATA_out;
    logic        top_UART_tx;
    wire  [7:0]  GPIO_PINS;

    logic [7:0]  tb_oe;
    logic [7:0]  tb_val;

    int errors = 0;
    int checks = 0;

    bit          chk_q[$];
    logic [31:0] exp_q[$];
    string       nm_q[$];
    bit          txexp_q[$];

    apb_gpio_uart_subsystem #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (32),
        .STROBE_WIDTH(4),
        .SLAVES_NUM  (2),
        .CLOCK_RATE  (160000),
        .BAUD_RATE   (10000)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .top_ADDR_in   (top_ADDR_in),
        .top_DATA_in   (top_DATA_in),
        .top_PROT_in   (top_PROT_in),
        .top_SEL_in    (top_SEL_in),
        .top_STROB_in  (top_STROB_in),
        .top_Transfer  (top_Transfer),
        .top_WRITE_in  (top_WRITE_in),
        .top_UART_rx   (top_UART_rx),
        .top_SLVERR_out(top_SLVERR_out),
        .top_DATA_out  (top_DATA_out),
        .top_UART_tx   (top_UART_tx),
        .GPIO_PINS     (GPIO_PINS)
    );

    for (genvar i = 0; i < 8; i++) begin : g_drv
        assign GPIO_PINS[i] = tb_oe[i] ? tb_val[i] : 1'bz;
    end

    always #5 CLK = ~CLK;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // One APB command; the expected read result is queued for the monitor.
    task automatic xfer(input logic [1:0] sel, input logic wr, input logic [1:0] addr,
                        input logic [31:0] data, input bit chk, input logic [31:0] exp,
                        input string nm);
        @(negedge CLK);
        top_SEL_in   = sel;
        top_WRITE_in = wr;
        top_ADDR_in  = {30'd0, addr};
        top_DATA_in  = data;
        top_PROT_in  = 3'd0;
        top_STROB_in = 4'hF;
        top_Transfer = 1'b1;
        chk_q.push_back(chk);
        exp_q.push_back(exp);
        nm_q.push_back(nm);
        @(negedge CLK);
        top_Transfer = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par_flip, input bit stop);
        logic [10:0] f;
        f = {stop, (^d) ^ par_flip, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            top_UART_rx = f[i];
            repeat (DIV) @(negedge CLK);
        end
        top_UART_rx = 1'b1;
        repeat (DIV) @(negedge CLK);
    endtask

    initial begin : monitor
        string       nm;
        logic [31:0] e;
        bit          c;
        forever begin
            @(negedge CLK);
            if (dut.penable_q) begin
                @(posedge CLK);
                #1;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_xfer: got transfer, expected none");
                end else begin
                    nm = nm_q.pop_front();
                    e  = exp_q.pop_front();
                    c  = chk_q.pop_front();
                    if (c) begin
                        check(nm, top_DATA_out, e);
                        check({nm, "_slverr"}, {31'd0, top_SLVERR_out}, 32'd0);
                    end
                end
            end
        end
    end

    initial begin : tx_mon
        forever begin
            @(posedge CLK);
            #1;
            if (txexp_q.size() != 0 && top_UART_tx == 1'b0) begin
                repeat (DIV / 2) @(posedge CLK);
                #1;
                check("tx_bit0", {31'd0, top_UART_tx}, {31'd0, txexp_q.pop_front()});
                for (int k = 1; k < 11; k++) begin
                    repeat (DIV) @(posedge CLK);
                    #1;
                    if (txexp_q.size() != 0)
                        check($sformatf("tx_bit%0d", k), {31'd0, top_UART_tx},
                              {31'd0, txexp_q.pop_front()});
                end
            end
        end
    end

    initial begin : timeout
        #500000;
        errors++;
        $display("FAIL timeout: got no end of test, expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [10:0] tx_frame;
        RST          = 1'b0;
        top_ADDR_in  = '0;
        top_DATA_in  = '0;
        top_PROT_in  = '0;
        top_SEL_in   = '0;
        top_STROB_in = '0;
        top_Transfer = 1'b0;
        top_WRITE_in = 1'b0;
        top_UART_rx  = 1'b1;
        tb_oe        = 8'h00;
        tb_val       = 8'h00;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("rst_data_out", top_DATA_out, 32'd0);
        check("rst_uart_tx", {31'd0, top_UART_tx}, 32'd1);
        check("rst_slverr", {31'd0, top_SLVERR_out}, 32'd0);

        // Pins are undriven after reset, so the bench can own all of them.
        tb_oe  = 8'hFF;
        tb_val = 8'hA5;
        xfer(2'b01, 1'b0, 2'd0, 32'd0, 1'b1, 32'h0000_00A5, "gpio_pins_hiz");
        tb_oe  = 8'h00;

        xfer(2'b01, 1'b1, 2'd2, 32'h0000_000F, 1'b0, 32'd0, "wr_dir");
        check("pins_lo_after_dir", {28'd0, GPIO_PINS[3:0]}, 32'h0);
        xfer(2'b01, 1'b1, 2'd3, 32'h0000_0007, 1'b0, 32'd0, "wr_port");
        check("pins_port7", {28'd0, GPIO_PINS[3:0]}, 32'h7);
        tb_oe  = 8'hF0;
        tb_val = 8'hD0;
        @(negedge CLK);
        check("pins_mixed", {24'd0, GPIO_PINS}, 32'h0000_00D7);

        xfer(2'b01, 1'b0, 2'd2, 32'd0, 1'b1, 32'h0000_000F, "rd_dir");
        xfer(2'b00, 1'b0, 2'd2, 32'd0, 1'b1, 32'h0000_0000, "rd_nosel");
        xfer(2'b01, 1'b0, 2'd3, 32'd0, 1'b1, 32'h0000_0007, "rd_port");
        xfer(2'b11, 1'b0, 2'd3, 32'd0, 1'b1, 32'h0000_0000, "rd_multisel");
        xfer(2'b01, 1'b0, 2'd0, 32'd0, 1'b1, 32'h0000_00D7, "rd_pins");
        xfer(2'b01, 1'b0, 2'd1, 32'd0, 1'b1, 32'h0000_0000, "rd_gpio_rsvd");
        xfer(2'b01, 1'b1, 2'd0, 32'h0000_00FF, 1'b0, 32'd0, "wr_pins_ro");
        xfer(2'b01, 1'b1, 2'd1, 32'h0000_00FF, 1'b0, 32'd0, "wr_gpio_rsvd");
        xfer(2'b01, 1'b0, 2'd0, 32'd0, 1'b1, 32'h0000_00D7, "rd_pins_again");
        xfer(2'b01, 1'b0, 2'd2, 32'd0, 1'b1, 32'h0000_000F, "rd_dir_again");

        // 0xA5 frame: start, 1,0,1,0,0,1,0,1, even parity 0, stop.
        tx_frame = 11'b1_0_1010_0101_0;
        for (int i = 0; i < 11; i++) txexp_q.push_back(tx_frame[i]);
        xfer(2'b10, 1'b1, 2'd0, 32'h0000_00A5, 1'b0, 32'd0, "wr_txdata");
        xfer(2'b10, 1'b0, 2'd2, 32'd0, 1'b1, 32'h0000_0001, "status_tx_busy");
        xfer(2'b10, 1'b1, 2'd0, 32'h0000_0000, 1'b0, 32'd0, "wr_txdata_busy");
        repeat (200) @(negedge CLK);
        xfer(2'b10, 1'b0, 2'd2, 32'd0, 1'b1, 32'h0000_0000, "status_tx_done");
        xfer(2'b10, 1'b0, 2'd3, 32'd0, 1'b1, 32'h0000_0000, "rd_uart_rsvd");

        send_frame(8'h55, 1'b0, 1'b1);
        xfer(2'b10, 1'b0, 2'd2, 32'd0, 1'b1, 32'h0000_0002, "status_rx_ok");
        xfer(2'b10, 1'b0, 2'd1, 32'd0, 1'b1, 32'h0000_0055, "rxdata_55");
        xfer(2'b10, 1'b0, 2'd2, 32'd0, 1'b1, 32'h0000_0000, "status_rx_clr");

        send_frame(8'h55, 1'b1, 1'b1);
        xfer(2'b10, 1'b0, 2'd2, 32'd0, 1'b1, 32'h0000_0006, "status_parity_err");
        xfer(2'b10, 1'b0, 2'd1, 32'd0, 1'b1, 32'h0000_0055, "rxdata_55_bad_par");
        xfer(2'b10, 1'b0, 2'd2, 32'd0, 1'b1, 32'h0000_0000, "status_perr_clr");

        send_frame(8'hA3, 1'b0, 1'b0);
        xfer(2'b10, 1'b0, 2'd2, 32'd0, 1'b1, 32'h0000_000A, "status_frame_err");
        xfer(2'b10, 1'b0, 2'd1, 32'd0, 1'b1, 32'h0000_00A3, "rxdata_a3");
        xfer(2'b10, 1'b0, 2'd2, 32'd0, 1'b1, 32'h0000_0000, "status_ferr_clr");

        repeat (5) @(negedge CLK);
        check("sb_drained", exp_q.size(), 32'd0);
        check("tx_drained", txexp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
